// File: rtl/segs_scan.sv
// segs_scan: N-digit hex seven-segment driver with static and scanned outputs.
// Latency: load -> seg_par_o two clk edges; scan outputs registered one edge after index.
// Backpressure: none; load is accepted on every edge it is high, including while disabled.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture value_in / dp_in into the shadow registers
//   value_in            packed hex digits, digit 0 in the low nibble
//   dp_in               decimal point per digit, 1 = lit
//   enable              0 forces every segment and digit select dark
//   lzb_en              1 blanks leading zero digits (digit 0 always shown)
//   seg_par_o           static segment bytes, active-low, digit k at [8k+7:8k]
//   seg_scan_o          segment byte of the selected digit, active-low
//   an_o                active-low one-hot digit select
//   scan_done           one-cycle pulse when the scan index wraps to 0
//   blink_mask          (SEGS_BLINK_EN only) digits that blink
//
// Optional feature macro: SEGS_BLINK_EN adds blink_mask and the blink phase logic.
module segs_scan #(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  input  logic                    lzb_en,
`ifdef SEGS_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [8*NUM_DIGITS-1:0] seg_par_o,
  output logic [7:0]              seg_scan_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    scan_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("segs_scan: NUM_DIGITS must be >= 1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("segs_scan: SCAN_DIV must be >= 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("segs_scan: BLINK_DIV must be >= 1");
  end

  // Active-high font, bit7..1 = a..g, bit0 = dp (left clear here).
  function automatic logic [7:0] hex_font(input logic [3:0] h);
    logic [7:0] f;
    case (h)
      4'h0: f = 8'hFC;
      4'h1: f = 8'h60;
      4'h2: f = 8'hDA;
      4'h3: f = 8'hF2;
      4'h4: f = 8'h66;
      4'h5: f = 8'hB6;
      4'h6: f = 8'hBE;
      4'h7: f = 8'hE0;
      4'h8: f = 8'hFE;
      4'h9: f = 8'hF6;
      4'hA: f = 8'hEE;
      4'hB: f = 8'h3E;
      4'hC: f = 8'h9C;
      4'hD: f = 8'h7A;
      4'hE: f = 8'h9E;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    term_cnt, wrap;
  logic [8*NUM_DIGITS-1:0] seg_par_q, seg_par_d;
  logic [7:0]              seg_scan_q, seg_scan_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    scan_done_q;

`ifdef SEGS_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  logic [BLK_W-1:0] blink_cnt_q;
  logic             phase_q;

  // Blink phase counts completed scan rounds, so it tracks the visible refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
    end
  end
`endif

  // Prescaler and scan index.
  always_comb begin
    term_cnt = (presc_q == PRE_LAST);
    wrap     = term_cnt && (idx_q == IDX_LAST);
    presc_d  = term_cnt ? '0 : presc_q + PRE_W'(1);
    idx_d    = idx_q;
    if (term_cnt) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Per-digit bytes from the shadow. Walk from the MSD down: a digit is a
  // leading zero until the first nonzero nibble has been seen.
  logic       seen_nz;
  logic       blank;
  logic [3:0] nib;
  logic [7:0] seg;

  always_comb begin
    seen_nz   = 1'b0;
    blank     = 1'b0;
    nib       = '0;
    seg       = '0;
    seg_par_d = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = value_q[4*k +: 4];
      if (nib != 4'h0) begin
        seen_nz = 1'b1;
      end
      blank = lzb_en && !seen_nz && (k != 0);
      // A blanked digit keeps its decimal point.
      seg   = (blank ? 8'h00 : hex_font(nib)) | {7'b0, dp_q[k]};
`ifdef SEGS_BLINK_EN
      if (phase_q && blink_mask[k]) begin
        seg = 8'h00;
      end
`endif
      seg_par_d[8*k +: 8] = ~seg;
    end
  end

  // Select and segment byte come from the same index so they switch together.
  always_comb begin
    seg_scan_d = 8'hFF;
    an_d       = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        seg_scan_d = seg_par_d[8*k +: 8];
        an_d[k]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      dp_q        <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      scan_done_q <= 1'b0;
      seg_par_q   <= '1;
      seg_scan_q  <= 8'hFF;
      an_q        <= '1;
    end else begin
      if (load) begin
        value_q <= value_in;
        dp_q    <= dp_in;
      end
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      scan_done_q <= wrap;
      // Disabling only masks the outputs; the scan keeps its position.
      if (enable) begin
        seg_par_q  <= seg_par_d;
        seg_scan_q <= seg_scan_d;
        an_q       <= an_d;
      end else begin
        seg_par_q  <= '1;
        seg_scan_q <= 8'hFF;
        an_q       <= '1;
      end
    end
  end

  assign seg_par_o  = seg_par_q;
  assign seg_scan_o = seg_scan_q;
  assign an_o       = an_q;
  assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_segs_scan.sv
// Directed bench for segs_scan: three instances (2 digits, 4 digits, 1 digit).
module tb_segs_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 2-digit instance, SCAN_DIV=4
  logic        load2, en2, lzb2;
  logic [7:0]  val2;
  logic [1:0]  dp2;
  logic [15:0] seg_par2;
  logic [7:0]  seg_scan2;
  logic [1:0]  an2;
  logic        done2;
`ifdef SEGS_BLINK_EN
  logic [1:0]  bm2;
  logic [3:0]  bm4;
  logic [0:0]  bm1;
`endif

  // 4-digit instance, SCAN_DIV=4
  logic        load4, en4, lzb4;
  logic [15:0] val4;
  logic [3:0]  dp4;
  logic [31:0] seg_par4;
  logic [7:0]  seg_scan4;
  logic [3:0]  an4;
  logic        done4;

  // 1-digit instance, SCAN_DIV=3
  logic        load1, en1, lzb1;
  logic [3:0]  val1;
  logic [0:0]  dp1;
  logic [7:0]  seg_par1;
  logic [7:0]  seg_scan1;
  logic [0:0]  an1;
  logic        done1;

  segs_scan #(.NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value_in(val2), .dp_in(dp2),
    .enable(en2), .lzb_en(lzb2),
`ifdef SEGS_BLINK_EN
    .blink_mask(bm2),
`endif
    .seg_par_o(seg_par2), .seg_scan_o(seg_scan2), .an_o(an2), .scan_done(done2)
  );

  segs_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load(load4), .value_in(val4), .dp_in(dp4),
    .enable(en4), .lzb_en(lzb4),
`ifdef SEGS_BLINK_EN
    .blink_mask(bm4),
`endif
    .seg_par_o(seg_par4), .seg_scan_o(seg_scan4), .an_o(an4), .scan_done(done4)
  );

  segs_scan #(.NUM_DIGITS(1), .SCAN_DIV(3), .BLINK_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .value_in(val1), .dp_in(dp1),
    .enable(en1), .lzb_en(lzb1),
`ifdef SEGS_BLINK_EN
    .blink_mask(bm1),
`endif
    .seg_par_o(seg_par1), .seg_scan_o(seg_scan1), .an_o(an1), .scan_done(done1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        lzb;
    logic [3:0]  dp;
    logic [15:0] val;
    logic [31:0] exp;
  } vec4_t;

  vec4_t tab4 [12] = '{
    '{1'b1, 4'b0000, 16'h0050, 32'hFFFF4903},
    '{1'b1, 4'b0000, 16'h0000, 32'hFFFFFF03},
    '{1'b1, 4'b0100, 16'h0000, 32'hFFFEFF03},
    '{1'b1, 4'b0000, 16'h1000, 32'h9F030303},
    '{1'b1, 4'b0000, 16'h0001, 32'hFFFFFF9F},
    '{1'b1, 4'b0000, 16'h0300, 32'hFF0D0303},
    '{1'b0, 4'b0000, 16'h0050, 32'h03034903},
    '{1'b0, 4'b0000, 16'h0123, 32'h039F250D},
    '{1'b0, 4'b0000, 16'h4567, 32'h9949411F},
    '{1'b0, 4'b0000, 16'h89AB, 32'h010911C1},
    '{1'b0, 4'b0000, 16'hCDEF, 32'h63856171},
    '{1'b0, 4'b1111, 16'h8888, 32'h00000000}
  };

  initial begin
    logic [3:0] exp_an4;
    logic [1:0] exp_an2;
    logic [7:0] exp_scan2;
    int         idx;

    rst_n = 1'b0;
    load2 = 1'b0; en2 = 1'b1; lzb2 = 1'b0; val2 = '0; dp2 = '0;
    load4 = 1'b0; en4 = 1'b1; lzb4 = 1'b0; val4 = '0; dp4 = '0;
    load1 = 1'b0; en1 = 1'b1; lzb1 = 1'b0; val1 = '0; dp1 = '0;
`ifdef SEGS_BLINK_EN
    bm2 = '0; bm4 = '0; bm1 = '0;
`endif
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_seg_par2", 32'(seg_par2), 32'hFFFF);
    chk("rst_seg_scan2", 32'(seg_scan2), 32'hFF);
    chk("rst_an2", 32'(an2), 32'h3);
    chk("rst_done2", 32'(done2), 32'h0);
    chk("rst_seg_par4", seg_par4, 32'hFFFFFFFF);
    chk("rst_seg_scan4", 32'(seg_scan4), 32'hFF);
    chk("rst_an4", 32'(an4), 32'hF);
    chk("rst_seg_par1", 32'(seg_par1), 32'hFF);
    chk("rst_seg_scan1", 32'(seg_scan1), 32'hFF);
    chk("rst_an1", 32'(an1), 32'h1);
    chk("rst_done1", 32'(done1), 32'h0);

    // Load 3A right at reset release: two-edge latency on the static bus
    val2 = 8'h3A; load2 = 1'b1; rst_n = 1'b1;
    chk("t1_before", 32'(seg_par2), 32'hFFFF);
    tick();
    load2 = 1'b0;
    chk("t1_edge1_old_shadow", 32'(seg_par2), 32'h0303);
    tick();
    chk("t1_edge2_value", 32'(seg_par2), 32'h0D11);

    // Scan sequence on 4 digits and 1 digit from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      idx = ((k - 1) / 4) % 4;
      exp_an4 = 4'hF;
      exp_an4[idx] = 1'b0;
      chk($sformatf("t2_an4_k%0d", k), 32'(an4), 32'(exp_an4));
      chk($sformatf("t2_done4_k%0d", k), 32'(done4), (k == 16) ? 32'h1 : 32'h0);
      chk($sformatf("t2_done1_k%0d", k), 32'(done1), (k % 3 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t2_an1_k%0d", k), 32'(an1), 32'h0);
    end

    // Leading-zero blanking, dp and font table on 4 digits
    for (int i = 0; i < 12; i++) begin
      lzb4 = tab4[i].lzb; dp4 = tab4[i].dp; val4 = tab4[i].val; load4 = 1'b1;
      tick();
      load4 = 1'b0;
      tick();
      chk($sformatf("t3_vec%0d_%h", i, tab4[i].val), seg_par4, tab4[i].exp);
    end

    // Decimal points on 2 digits, shadow hold, load while disabled
    dp2 = 2'b01; val2 = 8'h88; load2 = 1'b1;
    tick();
    load2 = 1'b0; val2 = 8'hFF; dp2 = 2'b10;
    tick();
    chk("t4_dp", 32'(seg_par2), 32'h0100);
    tick();
    tick();
    chk("t4_hold", 32'(seg_par2), 32'h0100);
    en2 = 1'b0; val2 = 8'h3A; dp2 = 2'b00; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    tick();
    chk("t4_disabled", 32'(seg_par2), 32'hFFFF);
    en2 = 1'b1;
    tick();
    chk("t4_load_while_disabled", 32'(seg_par2), 32'h0D11);

    // Enable drop mid-scan; index keeps counting underneath
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; val2 = 8'h3A; dp2 = 2'b00; load2 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      en2 = (k < 7 || k > 10);
      tick();
      load2 = 1'b0;
      idx = ((k - 1) / 4) % 2;
      if (k >= 7 && k <= 10) begin
        chk($sformatf("t5_off_an_k%0d", k), 32'(an2), 32'h3);
        chk($sformatf("t5_off_scan_k%0d", k), 32'(seg_scan2), 32'hFF);
        chk($sformatf("t5_off_par_k%0d", k), 32'(seg_par2), 32'hFFFF);
      end else begin
        exp_an2 = (idx == 0) ? 2'b10 : 2'b01;
        exp_scan2 = (k == 1) ? 8'h03 : ((idx == 0) ? 8'h11 : 8'h0D);
        chk($sformatf("t5_an_k%0d", k), 32'(an2), 32'(exp_an2));
        chk($sformatf("t5_scan_k%0d", k), 32'(seg_scan2), 32'(exp_scan2));
      end
      chk($sformatf("t5_done2_k%0d", k), 32'(done2), (k % 8 == 0) ? 32'h1 : 32'h0);
    end

    // Mid-cycle reset acts without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_par2", 32'(seg_par2), 32'hFFFF);
    chk("t5_async_scan2", 32'(seg_scan2), 32'hFF);
    chk("t5_async_an2", 32'(an2), 32'h3);
    chk("t5_async_par4", seg_par4, 32'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_after_rst_an2", 32'(an2), 32'h2);
    chk("t5_after_rst_scan2", 32'(seg_scan2), 32'h03);
    chk("t5_after_rst_par2", 32'(seg_par2), 32'h0303);

`ifdef SEGS_BLINK_EN
    // Blink: phase flips every 2 scan rounds (16 clks at N=2, SCAN_DIV=4)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; bm2 = 2'b01; val2 = 8'h3A; dp2 = 2'b00; load2 = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      load2 = 1'b0;
      if (k == 16) chk("t6_k16", 32'(seg_par2), 32'h0D11);
      if (k == 17) chk("t6_k17", 32'(seg_par2), 32'h0DFF);
      if (k == 17) chk("t6_k17_scan", 32'(seg_scan2), 32'hFF);
      if (k == 21) chk("t6_k21_scan", 32'(seg_scan2), 32'h0D);
      if (k == 32) chk("t6_k32", 32'(seg_par2), 32'h0DFF);
      if (k == 33) chk("t6_k33", 32'(seg_par2), 32'h0D11);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
